folded_dot_product: RTL and testbench

//   Time-multiplexed dot-product engine for the feature x weight stage.

---
 rtl/folded_dot_product_if.sv | 26 ++
 rtl/folded_dot_product.sv | 113 +++++++++++
 tb/tb_folded_dot_product.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/folded_dot_product_if.sv
// Start/busy and valid/ready bundle between operand fetch,
// the folded dot-product engine and the result consumer.
interface folded_dot_product_if #(
    parameter int FEATURE_COLS   = 96,
    parameter int WEIGHT_WIDTH   = 5,
    parameter int DOT_PROD_WIDTH = 16
);
    logic                                       start;
    logic                                       busy;
    logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]  feature_row;
    logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]  weight_col;
    logic                                       result_valid;
    logic                                       result_ready;
    logic [DOT_PROD_WIDTH-1:0]                  dot_product_result;
    logic                                       overflow;

    modport master (
        output start, feature_row, weight_col, result_ready,
        input  busy, result_valid, dot_product_result, overflow
    );

    modport slave (
        input  start, feature_row, weight_col, result_ready,
        output busy, result_valid, dot_product_result, overflow
    );
endinterface

// File: rtl/folded_dot_product.sv
// Time-multiplexed dot product: LANES multipliers folded over
// FEATURE_COLS/LANES cycles into a wide accumulator.
module folded_dot_product #(
    parameter int FEATURE_COLS   = 96,
    parameter int LANES          = 24,
    parameter int WEIGHT_WIDTH   = 5,
    parameter int DOT_PROD_WIDTH = 16,
    parameter bit SATURATE       = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    folded_dot_product_if.slave bus
);
    localparam int NUM_STEPS = FEATURE_COLS / LANES;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int PROD_W    = 2 * WEIGHT_WIDTH;
    localparam int ACC_W     = PROD_W + $clog2(FEATURE_COLS) + 1;
    localparam int SLICE_W   = LANES * WEIGHT_WIDTH;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [ACC_W-1:0]  MAX_RES   = ACC_W'({DOT_PROD_WIDTH{1'b1}});

    generate
        if (FEATURE_COLS % LANES != 0) begin : g_lanes_check
            $error("FEATURE_COLS must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                              state;
    logic [STEP_W-1:0]                   step;
    logic [ACC_W-1:0]                    acc;
    logic [ACC_W-1:0]                    lane_sum;
    logic [ACC_W-1:0]                    full;
    logic [NUM_STEPS-1:0][SLICE_W-1:0]   f_steps;
    logic [NUM_STEPS-1:0][SLICE_W-1:0]   w_steps;
    logic [LANES-1:0][WEIGHT_WIDTH-1:0]  f_lane;
    logic [LANES-1:0][WEIGHT_WIDTH-1:0]  w_lane;
    logic [LANES-1:0][ACC_W-1:0]         prod;

    // Reshape the operand rows so each step selects one LANES-wide slice.
    assign f_steps = bus.feature_row;
    assign w_steps = bus.weight_col;
    assign f_lane  = f_steps[step];
    assign w_lane  = w_steps[step];

    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_mul
            assign prod[j] = ACC_W'(PROD_W'(f_lane[j]) * PROD_W'(w_lane[j]));
        end
    endgenerate

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + prod[i];
        end
    end

    assign full = acc + lane_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            step                   <= '0;
            acc                    <= '0;
            bus.busy               <= 1'b0;
            bus.result_valid       <= 1'b0;
            bus.dot_product_result <= '0;
            bus.overflow           <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= CALC;
                        step     <= '0;
                        acc      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= full;
                    if (step == LAST_STEP) begin
                        state            <= DONE;
                        bus.result_valid <= 1'b1;
                        bus.overflow     <= (full > MAX_RES);
                        if (SATURATE && (full > MAX_RES)) begin
                            bus.dot_product_result <= '1;
                        end else begin
                            bus.dot_product_result <= full[DOT_PROD_WIDTH-1:0];
                        end
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                DONE: begin
                    // Result and overflow keep their value after the accept.
                    if (bus.result_ready) begin
                        state            <= IDLE;
                        bus.busy         <= 1'b0;
                        bus.result_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_folded_dot_product.sv
// Directed checks of the folded dot-product engine in four
// configurations driven from one shared stimulus.
module tb_folded_dot_product;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic ready;
    logic [95:0][4:0] f;
    logic [95:0][4:0] w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    folded_dot_product_if b_def  ();
    folded_dot_product_if b_wrap ();
    folded_dot_product_if b_l1   ();
    folded_dot_product_if b_l96  ();

    assign b_def.start        = start;
    assign b_def.result_ready = ready;
    assign b_def.feature_row  = f;
    assign b_def.weight_col   = w;
    assign b_wrap.start        = start;
    assign b_wrap.result_ready = ready;
    assign b_wrap.feature_row  = f;
    assign b_wrap.weight_col   = w;
    assign b_l1.start        = start;
    assign b_l1.result_ready = ready;
    assign b_l1.feature_row  = f;
    assign b_l1.weight_col   = w;
    assign b_l96.start        = start;
    assign b_l96.result_ready = ready;
    assign b_l96.feature_row  = f;
    assign b_l96.weight_col   = w;

    folded_dot_product #(.LANES(24), .SATURATE(1'b1)) u_def (
        .clk(clk), .reset(reset), .bus(b_def));
    folded_dot_product #(.LANES(24), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .bus(b_wrap));
    folded_dot_product #(.LANES(1), .SATURATE(1'b1)) u_l1 (
        .clk(clk), .reset(reset), .bus(b_l1));
    folded_dot_product #(.LANES(96), .SATURATE(1'b1)) u_l96 (
        .clk(clk), .reset(reset), .bus(b_l96));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model(input logic [95:0][4:0] a,
                                 input logic [95:0][4:0] b);
        int s = 0;
        for (int i = 0; i < 96; i++) s += int'(a[i]) * int'(b[i]);
        return s;
    endfunction

    task automatic fill(input int fv, input int wv);
        for (int i = 0; i < 96; i++) begin
            f[i] = 5'(fv);
            w[i] = 5'(wv);
        end
    endtask

    // Pulse start for one edge and let the 24-lane instances finish.
    task automatic run_calc();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain();
        int n = 0;
        ready = 1'b1;
        while ((b_def.busy || b_wrap.busy || b_l1.busy || b_l96.busy) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (b_def.busy || b_wrap.busy || b_l1.busy || b_l96.busy) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
        ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        fill(0, 0);
        repeat (2) tick();
        reset = 1'b0;
        checks++;
        if (b_def.busy !== 1'b0 || b_def.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b valid=%b required 0 0",
                     b_def.busy, b_def.result_valid);
        end
        checks++;
        if (b_def.dot_product_result !== 16'd0 || b_def.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: result=%0d ovf=%b required 0 0",
                     b_def.dot_product_result, b_def.overflow);
        end
        checks++;
        if (b_l1.result_valid !== 1'b0 || b_l96.result_valid !== 1'b0
            || b_wrap.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_others: l1=%b l96=%b wrap_busy=%b required 0 0 0",
                     b_l1.result_valid, b_l96.result_valid, b_wrap.busy);
        end
    endtask

    task automatic test_all_ones();
        fill(1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (b_def.busy !== 1'b1) begin
            errors++;
            $display("FAIL ones_busy: busy=%b required 1", b_def.busy);
        end
        repeat (3) tick();
        checks++;
        if (b_def.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL ones_early: valid=%b after 3 edges required 0",
                     b_def.result_valid);
        end
        tick();
        checks++;
        if (b_def.result_valid !== 1'b1 || b_def.dot_product_result !== 16'd96
            || b_def.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ones_result: valid=%b result=%0d ovf=%b required 1 96 0",
                     b_def.result_valid, b_def.dot_product_result, b_def.overflow);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (b_def.busy !== 1'b0 || b_def.result_valid !== 1'b0
            || b_def.dot_product_result !== 16'd96) begin
            errors++;
            $display("FAIL ones_accept: busy=%b valid=%b result=%0d required 0 0 96",
                     b_def.busy, b_def.result_valid, b_def.dot_product_result);
        end
        drain();
    endtask

    task automatic test_overflow();
        fill(31, 31);
        run_calc();
        checks++;
        if (b_def.dot_product_result !== 16'd65535 || b_def.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_result: result=%0d ovf=%b required 65535 1",
                     b_def.dot_product_result, b_def.overflow);
        end
        checks++;
        if (b_wrap.dot_product_result !== 16'd26720 || b_wrap.overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap_result: result=%0d ovf=%b required 26720 1",
                     b_wrap.dot_product_result, b_wrap.overflow);
        end
        drain();
        checks++;
        if (b_l1.dot_product_result !== 16'd65535 || b_l96.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_cfgs: l1=%0d l96_ovf=%b required 65535 1",
                     b_l1.dot_product_result, b_l96.overflow);
        end
    endtask

    task automatic test_slice_mapping();
        int idx [4] = '{23, 24, 71, 72};
        int fv  [4] = '{4, 6, 31, 13};
        int wv  [4] = '{9, 7, 2, 13};
        int exp_v [4] = '{36, 42, 62, 169};
        fill(0, 0);
        f[0]  = 5'd2;
        w[0]  = 5'd5;
        f[95] = 5'd3;
        w[95] = 5'd7;
        run_calc();
        checks++;
        if (b_def.dot_product_result !== 16'd31) begin
            errors++;
            $display("FAIL slice_ends: result=%0d required 31",
                     b_def.dot_product_result);
        end
        drain();
        for (int k = 0; k < 4; k++) begin
            fill(0, 0);
            f[idx[k]] = 5'(fv[k]);
            w[idx[k]] = 5'(wv[k]);
            run_calc();
            checks++;
            if (b_def.dot_product_result !== 16'(exp_v[k])) begin
                errors++;
                $display("FAIL slice_i%0d: result=%0d required %0d",
                         idx[k], b_def.dot_product_result, exp_v[k]);
            end
            drain();
            checks++;
            if (b_l1.dot_product_result !== 16'(exp_v[k])
                || b_l96.dot_product_result !== 16'(exp_v[k])) begin
                errors++;
                $display("FAIL slice_cfg_i%0d: l1=%0d l96=%0d required %0d",
                         idx[k], b_l1.dot_product_result,
                         b_l96.dot_product_result, exp_v[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        fill(31, 31);
        run_calc();
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (b_def.result_valid !== 1'b1 || b_def.busy !== 1'b1
                || b_def.dot_product_result !== 16'd65535
                || b_def.overflow !== 1'b1) begin
                errors++;
                $display("FAIL hold_c%0d: valid=%b busy=%b result=%0d ovf=%b required 1 1 65535 1",
                         c, b_def.result_valid, b_def.busy,
                         b_def.dot_product_result, b_def.overflow);
            end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (b_def.busy !== 1'b0 || b_def.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_ignores_start: busy=%b valid=%b required 0 0",
                     b_def.busy, b_def.result_valid);
        end
        tick();
        start = 1'b0;
        checks++;
        if (b_def.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_after_accept: busy=%b required 1", b_def.busy);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        fill(1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (b_def.busy !== 1'b0 || b_def.result_valid !== 1'b0
            || b_def.dot_product_result !== 16'd0 || b_def.overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b valid=%b result=%0d ovf=%b required 0 0 0 0",
                     b_def.busy, b_def.result_valid,
                     b_def.dot_product_result, b_def.overflow);
        end
        run_calc();
        checks++;
        if (b_def.result_valid !== 1'b1 || b_def.dot_product_result !== 16'd96) begin
            errors++;
            $display("FAIL after_reset: valid=%b result=%0d required 1 96",
                     b_def.result_valid, b_def.dot_product_result);
        end
        drain();
    endtask

    task automatic test_configs(input int lo);
        int full;
        logic [15:0] sat;
        for (int i = 0; i < 96; i++) begin
            f[i] = 5'($urandom_range(31, lo));
            w[i] = 5'($urandom_range(31, lo));
        end
        full = model(f, w);
        sat = (full > 65535) ? 16'hFFFF : 16'(full);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (b_l96.result_valid !== 1'b1 || b_l96.dot_product_result !== sat
            || b_l96.overflow !== (full > 65535)) begin
            errors++;
            $display("FAIL l96_lo%0d: valid=%b result=%0d ovf=%b required 1 %0d %b",
                     lo, b_l96.result_valid, b_l96.dot_product_result,
                     b_l96.overflow, sat, full > 65535);
        end
        repeat (94) tick();
        checks++;
        if (b_l1.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL l1_early_lo%0d: valid=%b after 95 edges required 0",
                     lo, b_l1.result_valid);
        end
        tick();
        checks++;
        if (b_l1.result_valid !== 1'b1 || b_l1.dot_product_result !== sat
            || b_l1.overflow !== (full > 65535)) begin
            errors++;
            $display("FAIL l1_lo%0d: valid=%b result=%0d ovf=%b required 1 %0d %b",
                     lo, b_l1.result_valid, b_l1.dot_product_result,
                     b_l1.overflow, sat, full > 65535);
        end
        checks++;
        if (b_wrap.dot_product_result !== 16'(full) || b_def.dot_product_result !== sat) begin
            errors++;
            $display("FAIL l24_lo%0d: wrap=%0d def=%0d required %0d %0d",
                     lo, b_wrap.dot_product_result, b_def.dot_product_result,
                     16'(full), sat);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_overflow();
        test_slice_mapping();
        test_back_to_back();
        test_mid_reset();
        test_configs(0);
        test_configs(24);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
